// File: rtl/tone_engine.sv
// tone_engine: square-wave tone for one of NUM_KEYS notes, chosen by live keys (lowest index wins)
// or, when TONE_SEQ_EN is defined, by a note/duration sequencer reading an external synchronous ROM.
module tone_engine #(
  parameter int NUM_KEYS = 8,
  parameter int DIV_W = 18,
  parameter logic [NUM_KEYS*DIV_W-1:0] HALF_PERIODS = {18'd95556, 18'd101239, 18'd113636, 18'd127552,
                                                       18'd143173, 18'd151686, 18'd170262, 18'd191113},
  parameter int ADDR_W = 6,
  parameter int BEAT_CYCLES = 25000000,
  parameter int GAP_CYCLES = 2500000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                mode,
  output logic [ADDR_W-1:0]   seq_addr,
  input  logic [3:0]          seq_note,
  input  logic [7:0]          seq_dur,
  output logic [3:0]          note,
  output logic                freq_out,
  output logic [NUM_KEYS-1:0] led
);

  localparam logic [3:0] NOTE_NONE = 4'hF;

  function automatic logic [3:0] lowest_key(input logic [NUM_KEYS-1:0] k);
    logic [3:0] idx;
    idx = NOTE_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (k[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [DIV_W-1:0] half_period(input logic [3:0] n);
    logic [DIV_W-1:0] hp;
    hp = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (n == 4'(i)) hp = HALF_PERIODS[i*DIV_W +: DIV_W];
    end
    return hp;
  endfunction

  logic [NUM_KEYS-1:0] key_s1_q, key_s2_q;
  logic [3:0]          live_note_s;
  logic [3:0]          note_d, note_q;
  logic [DIV_W-1:0]    div_d, div_q;
  logic                freq_d, freq_q;
  logic [NUM_KEYS-1:0] led_d, led_q;

  assign live_note_s = lowest_key(key_s2_q);

`ifdef TONE_SEQ_EN
  localparam int CNT_MAX = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LOAD, S_PLAY, S_GAP, S_HALT} state_t;

  state_t            state_d, state_q;
  logic              mode_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [7:0]        dur_d, dur_q;
  logic [7:0]        beat_d, beat_q;
  logic [CNT_W-1:0]  cyc_d, cyc_q;

  // Sequencer next state; a note lasts dur beats of BEAT_CYCLES, counted without a multiplier.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dur_d   = dur_q;
    beat_d  = beat_q;
    cyc_d   = cyc_q;
    note_d  = note_q;
    if (!mode_q) begin
      state_d = S_IDLE;
      addr_d  = '0;
      beat_d  = 8'd0;
      cyc_d   = '0;
      note_d  = live_note_s;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ADDR;
          note_d  = NOTE_NONE;
        end
        S_ADDR: state_d = S_LOAD;
        S_LOAD: begin
          dur_d = seq_dur;
          if (seq_dur == 8'd0) begin
            if (addr_q != '0) begin
              addr_d  = '0;
              state_d = S_ADDR;
            end else begin
              state_d = S_HALT;
            end
          end else begin
            state_d = S_PLAY;
            note_d  = (seq_note < 4'(NUM_KEYS)) ? seq_note : NOTE_NONE;
          end
        end
        S_PLAY: begin
          if (cyc_q == BEAT_LAST) begin
            cyc_d = '0;
            if (beat_q == dur_q - 8'd1) begin
              beat_d  = 8'd0;
              state_d = S_GAP;
              note_d  = NOTE_NONE;
            end else begin
              beat_d = beat_q + 8'd1;
            end
          end else begin
            cyc_d = cyc_q + CNT_W'(1'b1);
          end
        end
        S_GAP: begin
          if (cyc_q == GAP_LAST) begin
            cyc_d   = '0;
            addr_d  = addr_q + ADDR_W'(1'b1);
            state_d = S_ADDR;
          end else begin
            cyc_d = cyc_q + CNT_W'(1'b1);
          end
        end
        S_HALT: note_d = NOTE_NONE;
        default: begin
          state_d = S_IDLE;
          note_d  = NOTE_NONE;
        end
      endcase
    end
  end

  // Sequencer state registers; mode is registered before the FSM acts on it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      dur_q   <= 8'd0;
      beat_q  <= 8'd0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
      addr_q  <= addr_d;
      dur_q   <= dur_d;
      beat_q  <= beat_d;
      cyc_q   <= cyc_d;
    end
  end

  assign seq_addr = addr_q;
`else
  logic unused_seq_s;

  assign unused_seq_s = ^{mode, seq_note, seq_dur};
  assign note_d = live_note_s;
  assign seq_addr = '0;
`endif

  // Tone divider and LED decode; any note change restarts the phase on the same edge.
  always_comb begin
    div_d  = div_q;
    freq_d = freq_q;
    led_d  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      led_d[i] = (note_d == 4'(i));
    end
    if ((note_d != note_q) || (note_d == NOTE_NONE)) begin
      div_d  = '0;
      freq_d = 1'b0;
    end else if (div_q == half_period(note_q) - DIV_W'(1'b1)) begin
      div_d  = '0;
      freq_d = ~freq_q;
    end else begin
      div_d = div_q + DIV_W'(1'b1);
    end
  end

  // Key synchroniser and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      note_q   <= NOTE_NONE;
      div_q    <= '0;
      freq_q   <= 1'b0;
      led_q    <= '0;
    end else begin
      key_s1_q <= key;
      key_s2_q <= key_s1_q;
      note_q   <= note_d;
      div_q    <= div_d;
      freq_q   <= freq_d;
      led_q    <= led_d;
    end
  end

  assign note     = note_q;
  assign freq_out = freq_q;
  assign led      = led_q;

endmodule

// File: tb/tb_tone_engine.sv
// Randomised bench for tone_engine: expected note/led/freq_out/seq_addr come from a key delay line,
// a precomputed song timeline and an arithmetic tone model (t / half_period parity).
module tb_tone_engine;

  localparam int NK = 8;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int BEAT = 4;
  localparam int GAP = 2;
  localparam int CAP = 600;
  localparam logic [NK*DW-1:0] HP = {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3};
  localparam logic [3:0] NONE = 4'hF;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [NK-1:0] key;
  logic          mode;
  logic [AW-1:0] seq_addr;
  logic [3:0]    seq_note;
  logic [7:0]    seq_dur;
  logic [3:0]    note;
  logic          freq_out;
  logic [NK-1:0] led;

  int         hp_tab [NK] = '{3, 4, 5, 6, 7, 8, 9, 10};
  logic [3:0] rom_n [1 << AW];
  logic [7:0] rom_d [1 << AW];

  int n_checks = 0;
  int n_fail = 0;

  logic [NK-1:0] key_hist [$];
  logic [3:0]    tl_note [$];
  logic [AW-1:0] tl_addr [$];
  logic          mode_prev;
  logic [3:0]    prev_note;
  int            t;

  tone_engine #(
    .NUM_KEYS(NK), .DIV_W(DW), .HALF_PERIODS(HP), .ADDR_W(AW),
    .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)
  ) dut (
    .CLK(CLK), .RESET(RESET), .key(key), .mode(mode), .seq_addr(seq_addr),
    .seq_note(seq_note), .seq_dur(seq_dur), .note(note), .freq_out(freq_out), .led(led)
  );

  always #5 CLK = ~CLK;

  // Synchronous song ROM: data for the registered address one cycle later.
  always @(posedge CLK) begin
    seq_note <= rom_n[seq_addr];
    seq_dur  <= rom_d[seq_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: observed %0h, expected %0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [NK-1:0] k);
    for (int i = 0; i < NK; i++) begin
      if (k[i]) return 4'(i);
    end
    return NONE;
  endfunction

  function automatic void tl_push(input logic [3:0] n, input int a);
    tl_note.push_back(n);
    tl_addr.push_back(AW'(a));
  endfunction

  // Expand the ROM table into (note, address) after each edge, starting with the IDLE->ADDR edge.
  task automatic build_timeline();
    int a;
    int dur;
    logic [3:0] n;
    tl_note.delete();
    tl_addr.delete();
    a = 0;
    tl_push(NONE, 0);
    while (tl_note.size() < CAP) begin
      tl_push(NONE, a);
      dur = int'(rom_d[a]);
      if (dur == 0) begin
        if (a != 0) begin
          a = 0;
          tl_push(NONE, 0);
        end else begin
          while (tl_note.size() < CAP) tl_push(NONE, 0);
        end
      end else begin
        n = (rom_n[a] < 4'(NK)) ? rom_n[a] : NONE;
        repeat (dur * BEAT) tl_push(n, a);
        repeat (GAP) tl_push(NONE, a);
        a = (a + 1) % (1 << AW);
        tl_push(NONE, a);
      end
    end
  endtask

  task automatic model_reset();
    key_hist.delete();
    key_hist.push_back('0);
    key_hist.push_back('0);
    mode_prev = 1'b0;
    prev_note = NONE;
    t = 0;
  endtask

  // One clock: advance the model and compare all outputs #1 after the edge.
  task automatic step();
    logic [NK-1:0] k_now;
    logic [NK-1:0] k_old;
    logic          m_now;
    logic [3:0]    exp_n;
    logic [AW-1:0] exp_a;
    logic          exp_f;
    logic [NK-1:0] exp_led;
    k_now = key;
    m_now = mode;
    @(posedge CLK);
    #1;
    key_hist.push_back(k_now);
    k_old = key_hist.pop_front();
    exp_n = lowest(k_old);
    exp_a = '0;
`ifdef TONE_SEQ_EN
    if (mode_prev) begin
      if (tl_note.size() > 0) begin
        exp_n = tl_note.pop_front();
        exp_a = tl_addr.pop_front();
      end else begin
        exp_n = NONE;
      end
    end else begin
      build_timeline();
    end
`endif
    mode_prev = m_now;
    if (exp_n != prev_note) t = 0;
    else t++;
    prev_note = exp_n;
    if (exp_n == NONE) begin
      exp_f = 1'b0;
      exp_led = '0;
    end else begin
      exp_f = ((t / hp_tab[exp_n]) % 2) == 1;
      exp_led = NK'(1) << exp_n;
    end
    check_eq("note", note, exp_n);
    check_eq("led", led, exp_led);
    check_eq("freq_out", freq_out, exp_f);
    check_eq("seq_addr", seq_addr, exp_a);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_note", note, NONE);
    check_eq("rst_freq_out", freq_out, 1'b0);
    check_eq("rst_led", led, '0);
    check_eq("rst_seq_addr", seq_addr, '0);
  endtask

  initial begin
    RESET = 1'b1;
    key = '0;
    mode = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      rom_n[i] = 4'd0;
      rom_d[i] = 8'd0;
    end
    rom_n[0] = 4'd1;  rom_d[0] = 8'd2;
    rom_n[1] = 4'hF;  rom_d[1] = 8'd1;
    rom_n[2] = 4'd3;  rom_d[2] = 8'd1;
    rom_n[3] = 4'd5;  rom_d[3] = 8'd0;
    #12;
    check_reset_outputs();
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    model_reset();

    // Live priority, phase restart on 2->5, then release.
    key = 8'b0010_0100;
    repeat (30) step();
    key = 8'b0010_0000;
    repeat (20) step();
    key = '0;
    repeat (10) step();

    // Mode high with a key held: the live note tracks the key unless the sequencer is built in.
    mode = 1'b1;
    key = 8'b0100_0000;
    repeat (20) step();
    mode = 1'b0;
    repeat (4) step();

    // Random keys and mode.
    for (int i = 0; i < 40; i++) begin
      key = NK'($urandom) << $urandom_range(0, NK - 1);
      mode = 1'($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 20)) step();
    end
    mode = 1'b0;
    repeat (4) step();

    // Asynchronous reset in the middle of a tone.
    key = 8'b0000_1000;
    repeat (13) step();
    #3;
    RESET = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge CLK);
    #2;
    RESET = 1'b0;
    model_reset();
    repeat (4) step();

`ifdef TONE_SEQ_EN
    // Directed song: note 1 x2 beats, rest x1, note 3 x1, end -> loop to 0.
    key = NK'($urandom);
    mode = 1'b1;
    repeat (70) step();
    // Drop mode during PLAY: live key appears, address returns to 0.
    mode = 1'b0;
    key = 8'b1000_0000;
    repeat (4) step();
    mode = 1'b1;
    repeat (6) step();
    mode = 1'b0;
    repeat (6) step();

    // Empty song halts silently.
    rom_d[0] = 8'd0;
    mode = 1'b1;
    repeat (20) step();
    mode = 1'b0;
    repeat (4) step();

    // Full table of one-beat notes wraps the address.
    for (int i = 0; i < (1 << AW); i++) begin
      rom_n[i] = 4'(i);
      rom_d[i] = 8'd1;
    end
    mode = 1'b1;
    repeat (80) step();
    mode = 1'b0;
    repeat (4) step();

    // Random songs with random keys held.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < (1 << AW); i++) begin
        rom_n[i] = 4'($urandom_range(0, 15));
        rom_d[i] = 8'($urandom_range(0, 3));
      end
      key = NK'($urandom);
      mode = 1'b1;
      repeat (120) step();
      mode = 1'b0;
      repeat (4) step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
